// File: rtl/enc_dec_arbiter.sv
// Round-robin arbiter that shares one enc/dec core between NREQ requesters.
// Each granted job is loaded into the core and started. The result, or a timeout, is held until the owner acks it.
module enc_dec_arbiter #(
    parameter int nk      = 8,
    parameter int nb      = 4,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                  in_clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*32*nb-1:0] req_msg_i,
    input  logic [NREQ*32*nk-1:0] req_key_i,
    input  logic [NREQ-1:0]       req_dec_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [32*nb-1:0]      core_msg_o,
    output logic [32*nk-1:0]      core_key_o,
    output logic                  core_dec_o,
    output logic                  core_start_o,
    input  logic                  core_done_i,
    input  logic [32*nb-1:0]      core_result_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic [32*nb-1:0]      rsp_data_o,
    output logic                  rsp_err_o,
    input  logic [NREQ-1:0]       rsp_ack_i,
    output logic                  busy_o
);
    localparam int MW = 32 * nb;
    localparam int KW = 32 * nk;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0]   NREQ_W = NREQ[IW:0];
    localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, owner_q, owner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NREQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
    logic [MW-1:0]   msg_q, msg_d, rsp_data_q, rsp_data_d;
    logic [KW-1:0]   key_q, key_d;
    logic            dec_q, dec_d, start_q, start_d, err_q, err_d, busy_q, busy_d;

    logic [2*NREQ-1:0] req_rot;
    logic [IW-1:0]     sel_off, sel;
    logic [IW:0]       sel_sum;
    logic [NREQ-1:0]   owner_oh;

    // Rotate requests so rr_q lands at bit 0; the lowest set bit is then the winner.
    always_comb begin
        req_rot = {req_i, req_i} >> rr_q;
        sel_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) sel_off = IW'(i);
        end
        sel_sum = {1'b0, rr_q} + {1'b0, sel_off};
        if (sel_sum >= NREQ_W) sel_sum = sel_sum - NREQ_W;
        sel = sel_sum[IW-1:0];
    end

    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        gnt_d       = '0;
        start_d     = 1'b0;
        msg_d       = msg_q;
        key_d       = key_q;
        dec_d       = dec_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (sel == IW'(i)) begin
                            msg_d = req_msg_i[i*MW +: MW];
                            key_d = req_key_i[i*KW +: KW];
                            dec_d = req_dec_i[i];
                        end
                    end
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
                    owner_d = sel;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // A done on the final timer cycle still counts as success.
                if (core_done_i) begin
                    rsp_data_d  = core_result_i;
                    err_d       = 1'b0;
                    rsp_valid_d = owner_oh;
                    state_d     = S_RESP;
                end else if (timer_q == TMAX) begin
                    rsp_data_d  = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = owner_oh;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                if (|(rsp_ack_i & owner_oh)) begin
                    rsp_valid_d = '0;
                    err_d       = 1'b0;
                    rr_d        = (owner_q == LAST) ? '0 : owner_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge in_clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            start_q     <= 1'b0;
            msg_q       <= '0;
            key_q       <= '0;
            dec_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            msg_q       <= msg_d;
            key_q       <= key_d;
            dec_q       <= dec_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign core_msg_o   = msg_q;
    assign core_key_o   = key_q;
    assign core_dec_o   = dec_q;
    assign core_start_o = start_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = busy_q;
endmodule
